ui_io_bridge: RTL and testbench
===============================

// Module: ui_io_bridge
// PURPOSE
//  Memory-mapped I/O front end between the processor data-memory port and UiController.
//  Decodes IO addresses into uiDevice/uiWrtEn/uiIn and returns registered read data.
//  Adds key-press capture: rising-edge detection on debounced keys, with sticky event
//  bits and saturating press counters, so firmware never misses a short press.
// PARAMETERS
//  DBITS    32            data/address width
//  IO_BASE  32'hF000_0000 base of 256-byte IO window (addr[DBITS-1:8] match)
//  CNT_W    8             width of each per-key press counter (4*CNT_W <= DBITS)
// PORTS
//  clk         in   1      system clock, all state on posedge
//  reset       in   1      asynchronous, active-low; clears all state
//  memAddr     in   DBITS  byte address from memory stage
//  memWrtEn    in   1      store strobe, 1 cycle
//  memRdEn     in   1      load strobe, 1 cycle
//  memDataIn   in   DBITS  store data
//  memDataOut  out  DBITS  load data, valid when memRdValid
//  memRdValid  out  1      1-cycle pulse, one cycle after an in-window memRdEn
//  memIoSel    out  1      comb: memAddr inside IO window
//  uiDevice    out  2      comb: device select to UiController
//  uiWrtEn     out  1      comb: write strobe to UiController (LEDR/HEX only)
//  uiIn        out  DBITS  comb: = memDataIn
//  uiOut       in   DBITS  read data from UiController
//  keyState    in   4      debounced keys from UiController, 1 = pressed
//  irq         out  1      key-event interrupt request (see CONFIGURATION)
// BEHAVIOUR
//  Map (offset = memAddr[7:0]): 00 KEY, 04 SW, 08 LEDR, 0C HEX -> pass-through to UiController;
//   10 KEVT[3:0] sticky press events, W1C; 14 KCTRL[3:0] irq mask; 18 KCNT {k3..k0}, CNT_W each,
//   any write clears all counters. Other offsets: read 0, writes ignored.
//  Decode comb; uiWrtEn = memWrtEn & memIoSel & offset in {08,0C}; uiDevice from offset[3:2].
//  Reads: memDataOut registered on posedge, latency 1; memRdValid pulses with it.
//   Out-of-window or unmapped read: memDataOut <= 0, memRdValid stays 0 if out of window.
//  Edge detect: keyPrev <= keyState each cycle; press[i] = keyState[i] & ~keyPrev[i].
//  KEVT[i] set on press[i]; cleared by write with memDataIn[i]=1. Same-cycle set & clear: set wins.
//  KCNT[i] += press[i], saturates at 2^CNT_W-1 (no wrap). Same-cycle press & clear-write: clear
//   applies, then that press counts -> result 1.
//  Read of KEVT/KCNT same cycle as a press returns pre-update value.
//  Reset (async, any time incl. mid-access): KEVT=0, KCNT=0, KCTRL=0, keyPrev=0,
//   memDataOut=0, memRdValid=0, irq=0. A key held through reset release is not a new press.
//  memWrtEn and memRdEn both high: write and read both performed; read returns old value.
// CONFIGURATION
//  UI_IRQ_EN defined: KCTRL read/write; irq registered = |(KEVT & KCTRL), asserts 1 cycle after
//   event set, deasserts 1 cycle after clear or mask.
//  UI_IRQ_EN undefined: KCTRL reads 0, writes ignored; irq tied 0; no mask flops.
// STRUCTURE
//  Shared header ui_pkg.vh: UI_KEY=0, UI_SW=1, UI_LEDR=2, UI_HEX=3; offset constants
//   OFF_KEY..OFF_KCNT; IO_BASE default. Shared with UiController.
//  One sub-module: key_event_capture (edge detect, KEVT, KCNT, irq); bridge holds decode + read mux.
// TESTING
//  1 Store 0x3FF to BASE+08 -> uiWrtEn=1, uiDevice=2, uiIn=0x3FF same cycle; store to BASE+00 -> uiWrtEn=0.
//  2 keyState 0000->0101 for 1 cycle -> KEVT=0x5, KCNT=0x00010001; load BASE+10 -> 0x5 next cycle.
//  3 KEVT=0xF, store 0x3 to BASE+10 while key2 rises -> KEVT=0xC (set-wins on bit2 irrelevant), then 0xC.
//  4 300 presses of key0 -> KCNT[7:0]=0xFF; store any to BASE+18 -> 0.
//  5 UI_IRQ_EN: KCTRL=0x2, press key1 -> irq=1 next cycle; W1C bit1 -> irq=0 next cycle; undefined -> irq always 0.
//  6 Assert reset mid-load with KEVT=0xF, keys held -> all outputs 0 async; release -> no events captured.

Source files
------------

// File: rtl/ui_io_bridge_pkg.sv
// Shared UI IO-window constants: device selects, register offsets, default base address.
// Device codes match the UiController's device select encoding.
package ui_io_bridge_pkg;

  typedef enum logic [1:0] {
    UI_KEY  = 2'd0,
    UI_SW   = 2'd1,
    UI_LEDR = 2'd2,
    UI_HEX  = 2'd3
  } ui_dev_e;

  localparam int NKEYS = 4;

  localparam logic [7:0] OFF_KEY   = 8'h00;
  localparam logic [7:0] OFF_SW    = 8'h04;
  localparam logic [7:0] OFF_LEDR  = 8'h08;
  localparam logic [7:0] OFF_HEX   = 8'h0C;
  localparam logic [7:0] OFF_KEVT  = 8'h10;
  localparam logic [7:0] OFF_KCTRL = 8'h14;
  localparam logic [7:0] OFF_KCNT  = 8'h18;

  localparam logic [31:0] IO_BASE_DEF = 32'hF000_0000;

  // True for the four word offsets forwarded to the UiController.
  function automatic logic is_ui_off(input logic [7:0] off);
    return (off[7:4] == 4'h0) && (off[1:0] == 2'b00);
  endfunction

endpackage

// File: rtl/ui_io_bridge_key_event_capture.sv
// Key-press capture: edge detect, sticky W1C events, saturating per-key counters.
// UI_IRQ_EN adds the irq mask register and registered irq; otherwise both read as 0.
module ui_io_bridge_key_event_capture
  import ui_io_bridge_pkg::*;
#(
  parameter int CNT_W = 8
) (
  input  logic                   i_clk,
  input  logic                   i_rst_n,
  input  logic [NKEYS-1:0]       i_key,
  input  logic                   i_wr_kevt,
  input  logic                   i_wr_kctrl,
  input  logic                   i_wr_kcnt,
  input  logic [NKEYS-1:0]       i_wdat,
  output logic [NKEYS-1:0]       o_kevt,
  output logic [NKEYS-1:0]       o_kctrl,
  output logic [NKEYS*CNT_W-1:0] o_kcnt,
  output logic                   o_irq
);

  logic [NKEYS-1:0] r_key_prev;
  logic [NKEYS-1:0] r_kevt;
  logic             r_armed;
  logic [CNT_W-1:0] r_kcnt [NKEYS];
  logic [NKEYS-1:0] w_press;

  // r_armed masks the first cycle after reset so a key held through release is not a press.
  assign w_press = i_key & ~r_key_prev & {NKEYS{r_armed}};

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_key_prev <= '0;
      r_armed    <= 1'b0;
      r_kevt     <= '0;
    end else begin
      r_key_prev <= i_key;
      r_armed    <= 1'b1;
      r_kevt     <= (r_kevt & ~(i_wr_kevt ? i_wdat : '0)) | w_press;
    end
  end

  // A clear-write and a press in the same cycle leave the counter at 1.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int i = 0; i < NKEYS; i++) r_kcnt[i] <= '0;
    end else begin
      for (int i = 0; i < NKEYS; i++) begin
        if (i_wr_kcnt)
          r_kcnt[i] <= CNT_W'(w_press[i]);
        else if (w_press[i] && (r_kcnt[i] != '1))
          r_kcnt[i] <= r_kcnt[i] + CNT_W'(1);
      end
    end
  end

  for (genvar g = 0; g < NKEYS; g++) begin : g_pack
    assign o_kcnt[g*CNT_W +: CNT_W] = r_kcnt[g];
  end

  assign o_kevt = r_kevt;

`ifdef UI_IRQ_EN
  logic [NKEYS-1:0] r_kctrl;
  logic             r_irq;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_kctrl <= '0;
      r_irq   <= 1'b0;
    end else begin
      if (i_wr_kctrl) r_kctrl <= i_wdat;
      r_irq <= |(r_kevt & r_kctrl);
    end
  end

  assign o_kctrl = r_kctrl;
  assign o_irq   = r_irq;
`else
  logic w_unused_kctrl;
  assign w_unused_kctrl = i_wr_kctrl;
  assign o_kctrl        = '0;
  assign o_irq          = 1'b0;
`endif

endmodule

// File: rtl/ui_io_bridge.sv
// UI IO bridge: comb address decode to UiController, loads registered with latency 1, no backpressure.
// Define UI_IRQ_EN to enable the KCTRL mask register and the key-event irq output.
module ui_io_bridge
  import ui_io_bridge_pkg::*;
#(
  parameter int               DBITS   = 32,
  parameter logic [DBITS-1:0] IO_BASE = DBITS'(IO_BASE_DEF),
  parameter int               CNT_W   = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [DBITS-1:0] memAddr,
  input  logic             memWrtEn,
  input  logic             memRdEn,
  input  logic [DBITS-1:0] memDataIn,
  output logic [DBITS-1:0] memDataOut,
  output logic             memRdValid,
  output logic             memIoSel,
  output logic [1:0]       uiDevice,
  output logic             uiWrtEn,
  output logic [DBITS-1:0] uiIn,
  input  logic [DBITS-1:0] uiOut,
  input  logic [3:0]       keyState,
  output logic             irq
);

  logic [7:0]             w_off;
  logic                   w_io_sel;
  logic                   w_wr;
  logic                   w_rd;
  ui_dev_e                w_dev;
  logic [NKEYS-1:0]       w_kevt;
  logic [NKEYS-1:0]       w_kctrl;
  logic [NKEYS*CNT_W-1:0] w_kcnt;
  logic [DBITS-1:0]       w_rd_mux;
  logic [DBITS-1:0]       r_rd_dat;
  logic                   r_rd_vld;

  assign w_off    = memAddr[7:0];
  assign w_io_sel = (memAddr[DBITS-1:8] == IO_BASE[DBITS-1:8]);
  assign w_dev    = ui_dev_e'(w_off[3:2]);
  assign w_wr     = memWrtEn & w_io_sel;
  assign w_rd     = memRdEn & w_io_sel;

  assign memIoSel = w_io_sel;
  assign uiDevice = w_off[3:2];
  assign uiIn     = memDataIn;
  // Only the output devices accept stores; KEY/SW are read-only on the UiController side.
  assign uiWrtEn  = w_wr & is_ui_off(w_off) & ((w_dev == UI_LEDR) | (w_dev == UI_HEX));

  ui_io_bridge_key_event_capture #(.CNT_W(CNT_W)) u_kec (
    .i_clk      (clk),
    .i_rst_n    (reset),
    .i_key      (keyState),
    .i_wr_kevt  (w_wr & (w_off == OFF_KEVT)),
    .i_wr_kctrl (w_wr & (w_off == OFF_KCTRL)),
    .i_wr_kcnt  (w_wr & (w_off == OFF_KCNT)),
    .i_wdat     (memDataIn[NKEYS-1:0]),
    .o_kevt     (w_kevt),
    .o_kctrl    (w_kctrl),
    .o_kcnt     (w_kcnt),
    .o_irq      (irq)
  );

  always_comb begin
    w_rd_mux = '0;
    case (w_off)
      OFF_KEY, OFF_SW, OFF_LEDR, OFF_HEX: w_rd_mux = uiOut;
      OFF_KEVT:                           w_rd_mux = DBITS'(w_kevt);
      OFF_KCTRL:                          w_rd_mux = DBITS'(w_kctrl);
      OFF_KCNT:                           w_rd_mux = DBITS'(w_kcnt);
      default:                            w_rd_mux = '0;
    endcase
  end

  // Register state is sampled before this edge's updates, so loads see pre-update values.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_rd_dat <= '0;
      r_rd_vld <= 1'b0;
    end else begin
      r_rd_vld <= w_rd;
      r_rd_dat <= w_rd ? w_rd_mux : '0;
    end
  end

  assign memDataOut = r_rd_dat;
  assign memRdValid = r_rd_vld;

endmodule

// File: tb/tb_ui_io_bridge.sv
// Directed and randomized bench for ui_io_bridge against a per-cycle reference model.
module tb_ui_io_bridge;

  localparam logic [31:0] BASE = 32'hF000_0000;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] memAddr;
  logic        memWrtEn;
  logic        memRdEn;
  logic [31:0] memDataIn;
  logic [31:0] memDataOut;
  logic        memRdValid;
  logic        memIoSel;
  logic [1:0]  uiDevice;
  logic        uiWrtEn;
  logic [31:0] uiIn;
  logic [31:0] uiOut;
  logic [3:0]  keyState;
  logic        irq;

  always #5 clk = ~clk;

  ui_io_bridge dut (
    .clk        (clk),
    .reset      (reset),
    .memAddr    (memAddr),
    .memWrtEn   (memWrtEn),
    .memRdEn    (memRdEn),
    .memDataIn  (memDataIn),
    .memDataOut (memDataOut),
    .memRdValid (memRdValid),
    .memIoSel   (memIoSel),
    .uiDevice   (uiDevice),
    .uiWrtEn    (uiWrtEn),
    .uiIn       (uiIn),
    .uiOut      (uiOut),
    .keyState   (keyState),
    .irq        (irq)
  );

  int vectors     = 0;
  int miscompares = 0;

  // Reference model state
  logic [3:0]  m_kevt;
  logic [3:0]  m_kctrl;
  logic [3:0]  m_prev;
  bit          m_armed;
  int          m_cnt [4];
  bit          e_vld;
  bit          e_irq;
  logic [31:0] e_dat;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_kevt  = '0;
    m_kctrl = '0;
    m_prev  = '0;
    m_armed = 0;
    for (int i = 0; i < 4; i++) m_cnt[i] = 0;
  endtask

  // Applies one clock edge's worth of architectural effects using the inputs now on the pins.
  task automatic model_tick();
    bit         in_win;
    logic [7:0] off;
    logic [3:0] pr;
    in_win = (memAddr[31:8] == BASE[31:8]);
    off    = memAddr[7:0];
    for (int i = 0; i < 4; i++) pr[i] = m_armed && keyState[i] && !m_prev[i];
    e_vld = memRdEn && in_win;
    e_dat = '0;
    if (e_vld) begin
      case (off)
        8'h00, 8'h04, 8'h08, 8'h0C: e_dat = uiOut;
        8'h10: e_dat = {28'd0, m_kevt};
        8'h14: e_dat = {28'd0, m_kctrl};
        8'h18: e_dat = 32'(m_cnt[0] + m_cnt[1] * 256 + m_cnt[2] * 65536 + m_cnt[3] * 16777216);
        default: e_dat = '0;
      endcase
    end
    e_irq = ((m_kevt & m_kctrl) != 4'd0);
    if (memWrtEn && in_win) begin
      case (off)
        8'h10: m_kevt = m_kevt & ~memDataIn[3:0];
        8'h14: begin
`ifdef UI_IRQ_EN
          m_kctrl = memDataIn[3:0];
`endif
        end
        8'h18: for (int i = 0; i < 4; i++) m_cnt[i] = 0;
        default: ;
      endcase
    end
    for (int i = 0; i < 4; i++) begin
      if (pr[i]) begin
        m_kevt[i] = 1'b1;
        if (m_cnt[i] < 255) m_cnt[i] = m_cnt[i] + 1;
      end
    end
    m_prev  = keyState;
    m_armed = 1;
  endtask

  task automatic cyc();
    bit rd_was;
    rd_was = memRdEn;
    model_tick();
    @(posedge clk);
    #1;
    chk("rd_vld", memRdValid, e_vld);
    if (rd_was) chk("rd_dat", memDataOut, e_dat);
    chk("irq", irq, e_irq);
  endtask

  task automatic rd(input logic [31:0] a, output logic [31:0] d);
    memAddr = a;
    memRdEn = 1;
    uiOut   = $urandom;
    cyc();
    d       = memDataOut;
    memRdEn = 0;
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] v);
    memAddr   = a;
    memDataIn = v;
    memWrtEn  = 1;
    cyc();
    memWrtEn  = 0;
  endtask

  initial begin
    logic [31:0] d;
    logic        irq_on;
`ifdef UI_IRQ_EN
    irq_on = 1'b1;
`else
    irq_on = 1'b0;
`endif
    reset = 0; memAddr = '0; memWrtEn = 0; memRdEn = 0;
    memDataIn = '0; uiOut = '0; keyState = '0;
    model_reset();
    #12;
    chk("rst_vld", memRdValid, 0);
    chk("rst_dat", memDataOut, 0);
    chk("rst_irq", irq, 0);
    @(negedge clk);
    reset = 1;

    // Combinational decode
    memAddr = BASE + 32'h08; memDataIn = 32'h3FF; memWrtEn = 1; #1;
    chk("t1_wrten_ledr", uiWrtEn, 1);
    chk("t1_dev_ledr", uiDevice, 2);
    chk("t1_uiin", uiIn, 32'h3FF);
    chk("t1_iosel", memIoSel, 1);
    memAddr = BASE; #1;
    chk("t1_wrten_key", uiWrtEn, 0);
    chk("t1_dev_key", uiDevice, 0);
    memAddr = BASE + 32'h0C; #1;
    chk("t1_wrten_hex", uiWrtEn, 1);
    memAddr = 32'h1000_0008; #1;
    chk("t1_iosel_out", memIoSel, 0);
    memWrtEn = 0; memAddr = '0;
    cyc();

    // Simple press capture
    keyState = 4'b0101; cyc();
    keyState = 4'b0000; cyc();
    rd(BASE + 32'h10, d); chk("t2_kevt", d, 32'h5);
    rd(BASE + 32'h18, d); chk("t2_kcnt", d, 32'h0001_0001);
    rd(BASE + 32'h40, d); chk("t2_unmapped", d, 32'h0);

    // W1C with a concurrent press, and set-wins
    keyState = 4'hF; cyc();
    keyState = 4'h0; cyc();
    rd(BASE + 32'h10, d); chk("t3_kevt_f", d, 32'hF);
    keyState = 4'b0100; wr(BASE + 32'h10, 32'h3);
    keyState = 4'b0000;
    rd(BASE + 32'h10, d); chk("t3_kevt_c", d, 32'hC);
    rd(BASE + 32'h18, d); chk("t3_kcnt", d, 32'h0103_0102);
    keyState = 4'b0100; wr(BASE + 32'h10, 32'h4);
    keyState = 4'b0000;
    rd(BASE + 32'h10, d); chk("t3_setwins", d, 32'hC);

    // Counter saturation and clear
    wr(BASE + 32'h18, $urandom);
    rd(BASE + 32'h18, d); chk("t4_clr", d, 32'h0);
    for (int n = 0; n < 300; n++) begin
      keyState = 4'b0001; cyc();
      keyState = 4'b0000; cyc();
    end
    rd(BASE + 32'h18, d); chk("t4_sat", d, 32'h0000_00FF);
    wr(BASE + 32'h18, 32'h0);
    rd(BASE + 32'h18, d); chk("t4_clr2", d, 32'h0);
    keyState = 4'b0001; wr(BASE + 32'h18, 32'h0);
    keyState = 4'b0000;
    rd(BASE + 32'h18, d); chk("t4_clr_press", d, 32'h1);

    // Interrupt mask and timing
    wr(BASE + 32'h10, 32'hF);
    wr(BASE + 32'h14, 32'h2);
    rd(BASE + 32'h14, d); chk("t5_kctrl", d, irq_on ? 32'h2 : 32'h0);
    keyState = 4'b0010; cyc();
    chk("t5_irq_setcyc", irq, 0);
    keyState = 4'b0000; cyc();
    chk("t5_irq_on", irq, irq_on);
    wr(BASE + 32'h10, 32'h2);
    chk("t5_irq_clrcyc", irq, irq_on);
    cyc();
    chk("t5_irq_off", irq, 0);
    keyState = 4'b0001; cyc();
    keyState = 4'b0000; cyc(); cyc();
    chk("t5_irq_masked", irq, 0);

    // Async reset in the middle of a load, keys held through release
    keyState = 4'hF; cyc(); cyc();
    memAddr = BASE + 32'h10; memRdEn = 1; cyc();
    chk("t6_pre_dat", memDataOut, 32'hF);
    #2; reset = 0; #1;
    chk("t6_rst_vld", memRdValid, 0);
    chk("t6_rst_dat", memDataOut, 0);
    chk("t6_rst_irq", irq, 0);
    model_reset();
    @(posedge clk); @(posedge clk); #1;
    chk("t6_hold_vld", memRdValid, 0);
    memRdEn = 0;
    @(negedge clk);
    reset = 1;
    cyc(); cyc();
    rd(BASE + 32'h10, d); chk("t6_kevt", d, 32'h0);
    rd(BASE + 32'h18, d); chk("t6_kcnt", d, 32'h0);

    // Randomized traffic against the model
    for (int n = 0; n < 400; n++) begin
      if ($urandom_range(0, 2) == 0) keyState = 4'($urandom);
      memAddr = BASE + 32'($urandom_range(0, 9) * 4);
      if ($urandom_range(0, 9) == 0) memAddr = $urandom;
      memDataIn = $urandom;
      uiOut     = $urandom;
      memRdEn   = ($urandom_range(0, 1) == 1);
      memWrtEn  = ($urandom_range(0, 4) == 0);
      cyc();
      memRdEn  = 0;
      memWrtEn = 0;
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
